// File: rtl/control_pkg.sv
// Shared control-path types and constants for the front end.
// The fetch stage uses the NOP encoding and the {pc, instr} buffer entry.
package control_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, in-order unbackpressured response.
interface fetch_unit_if;
    import control_pkg::*;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO; push and pop may coincide, clear empties it next edge.
module fetch_fifo
    import control_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC ownership, credit-limited imem requests, response buffering,
// redirect squashing and the IF/ID register feeding decode.
module fetch_unit
    import control_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               id_stall,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4
);

    localparam logic [2:0] CREDITS = 3'(MAX_OUTSTANDING);

    logic [31:0]  pc_q, pc_d;
    logic [1:0]   drop_cnt_q, drop_cnt_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;
    logic [31:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]  if_id_pc4_q, if_id_pc4_d;

    logic [31:0]  pcq_head;
    logic [1:0]   inflight;
    logic         pcq_empty;
    logic [63:0]  ibuf_head_raw;
    fetch_entry_t ibuf_head;
    fetch_entry_t live;
    logic [1:0]   ibuf_count;
    logic         ibuf_empty;
    logic [2:0]   occupancy;
    logic         req_valid, req_fire, rsp_fire, dropping, deliver;
    logic         ibuf_push, ibuf_pop;

    // Every accepted request has exactly one pcq entry until its response returns.
    fetch_fifo #(.WIDTH(32)) u_pcq (
        .clk(clk), .rst(rst),
        .push(req_fire), .pop(rsp_fire), .clear(1'b0),
        .push_data(pc_q), .head(pcq_head),
        .count(inflight), .empty(pcq_empty)
    );

    fetch_fifo #(.WIDTH(64)) u_ibuf (
        .clk(clk), .rst(rst),
        .push(ibuf_push), .pop(ibuf_pop), .clear(redirect_valid),
        .push_data(live), .head(ibuf_head_raw),
        .count(ibuf_count), .empty(ibuf_empty)
    );

    assign ibuf_head = ibuf_head_raw;
    assign live      = '{pc: pcq_head, instr: imem.imem_rsp_data};

    always_comb begin
        occupancy = {1'b0, inflight} + {1'b0, ibuf_count};
        req_valid = !rst && !redirect_valid && (occupancy < CREDITS);
        req_fire  = req_valid && imem.imem_req_ready;
        rsp_fire  = imem.imem_rsp_valid && !pcq_empty;
        dropping  = (drop_cnt_q != 2'd0);
        deliver   = rsp_fire && !dropping && !redirect_valid;
        ibuf_pop  = !redirect_valid && !id_stall && !ibuf_empty;
        ibuf_push = deliver && (id_stall || !ibuf_empty);
    end

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = word_align(redirect_pc);
            // The response arriving now is squashed here, the rest by drop_cnt.
            drop_cnt_d = inflight - 2'(rsp_fire);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (rsp_fire && dropping) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end
        end
    end

    always_comb begin
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if (redirect_valid || (!id_stall && ibuf_empty && !deliver)) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = INSTR_NOP;
        end else if (!id_stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = ibuf_empty ? live.instr : ibuf_head.instr;
            if_id_pc_d    = ibuf_empty ? live.pc    : ibuf_head.pc;
            if_id_pc4_d   = if_id_pc_d + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            drop_cnt_q    <= 2'd0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= INSTR_NOP;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_pc4_q   <= 32'h0000_0004;
        end else begin
            pc_q          <= pc_d;
            drop_cnt_q    <= drop_cnt_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;
    assign if_id_valid         = if_id_valid_q;
    assign if_id_instr         = if_id_instr_q;
    assign if_id_pc            = if_id_pc_q;
    assign if_id_pc4           = if_id_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;
    import control_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;

    int n_chk  = 0;
    int n_fail = 0;
    int lat    = 1;
    int cyc    = 0;

    logic [31:0] q_addr [$];
    int          q_due  [$];

    always #5 clk = ~clk;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC       (32'h0000_0100),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_stall      (id_stall),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_if_id(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        check_eq({tag, "_pc"},    if_id_pc,         pc);
        check_eq({tag, "_pc4"},   if_id_pc4,        pc + 32'd4);
        check_eq({tag, "_instr"}, if_id_instr,      instr_of(pc));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Memory: responds lat cycles after acceptance, in order, one per cycle.
    initial begin
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                q_addr.delete();
                q_due.delete();
                imem.imem_rsp_valid = 1'b0;
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = instr_of(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem.imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (!rst && imem.imem_req_valid && imem.imem_req_ready) begin
                q_addr.push_back(imem.imem_req_addr);
                q_due.push_back(cyc + lat);
            end
        end
    end

    // Leaves the bench at the input-drive point of cycle 0 (first cycle out of reset).
    task automatic do_reset(input int l);
        nxt();
        rst                 = 1'b1;
        id_stall            = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        imem.imem_req_ready = 1'b1;
        lat                 = l;
        nxt();
        smp();
        check_eq("rst_if_id_valid", 32'(if_id_valid), 32'd0);
        check_eq("rst_if_id_instr", if_id_instr, INSTR_NOP);
        check_eq("rst_if_id_pc",    if_id_pc,    32'h0);
        check_eq("rst_if_id_pc4",   if_id_pc4,   32'h4);
        check_eq("rst_req_valid",   32'(imem.imem_req_valid), 32'd0);
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ab_pc [14];
        logic [31:0] exp_addr, exp_id, held_addr;
        logic        hold_pending;
        ab_pc = '{32'h0, 32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                  32'h110, 32'h110, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h120};
        imem.imem_req_ready = 1'b1;

        // Streaming at L=1 with a 3-cycle stall in the middle.
        do_reset(1);
        for (int t = 0; t < 14; t++) begin
            if (t > 0) nxt();
            id_stall = (t >= 6 && t <= 8);
            smp();
            if (t == 0) begin
                check_eq("ab_t0_req_valid", 32'(imem.imem_req_valid), 32'd1);
                check_eq("ab_t0_req_addr",  imem.imem_req_addr, 32'h100);
            end
            if (t < 2) check_eq($sformatf("ab_t%0d_valid", t), 32'(if_id_valid), 32'd0);
            else       expect_if_id($sformatf("ab_t%0d", t), ab_pc[t]);
            if (t >= 7 && t <= 9)
                check_eq($sformatf("ab_t%0d_req_valid", t), 32'(imem.imem_req_valid), 32'd0);
            if (t == 10) begin
                check_eq("ab_t10_req_valid", 32'(imem.imem_req_valid), 32'd1);
                check_eq("ab_t10_req_addr",  imem.imem_req_addr, 32'h11C);
            end
        end

        // L=2: redirect with two requests in flight, one response arriving.
        do_reset(2);
        for (int t = 0; t < 7; t++) begin
            if (t > 0) nxt();
            redirect_valid = (t == 2);
            redirect_pc    = 32'h2000;
            smp();
            case (t)
                2: check_eq("c_t2_req_valid", 32'(imem.imem_req_valid), 32'd0);
                3: begin
                    check_eq("c_t3_req_addr", imem.imem_req_addr, 32'h2000);
                    check_eq("c_t3_valid",    32'(if_id_valid), 32'd0);
                    check_eq("c_t3_instr",    if_id_instr, INSTR_NOP);
                end
                4: begin
                    check_eq("c_t4_req_addr", imem.imem_req_addr, 32'h2004);
                    check_eq("c_t4_valid",    32'(if_id_valid), 32'd0);
                end
                5: begin
                    check_eq("c_t5_valid",     32'(if_id_valid), 32'd0);
                    check_eq("c_t5_req_valid", 32'(imem.imem_req_valid), 32'd0);
                end
                6: expect_if_id("c_t6", 32'h2000);
                default: ;
            endcase
        end

        // Redirect colliding with id_stall, a buffered entry and an arriving response.
        do_reset(1);
        for (int t = 0; t < 9; t++) begin
            if (t > 0) nxt();
            id_stall       = (t == 3 || t == 4);
            redirect_valid = (t == 4);
            redirect_pc    = 32'h3000;
            smp();
            case (t)
                3: begin
                    expect_if_id("d_t3", 32'h104);
                    check_eq("d_t3_req_addr", imem.imem_req_addr, 32'h10C);
                end
                4: begin
                    expect_if_id("d_t4", 32'h104);
                    check_eq("d_t4_req_valid", 32'(imem.imem_req_valid), 32'd0);
                end
                5: begin
                    check_eq("d_t5_valid",    32'(if_id_valid), 32'd0);
                    check_eq("d_t5_instr",    if_id_instr, INSTR_NOP);
                    check_eq("d_t5_pc",       if_id_pc,    32'h104);
                    check_eq("d_t5_pc4",      if_id_pc4,   32'h108);
                    check_eq("d_t5_req_addr", imem.imem_req_addr, 32'h3000);
                end
                6: check_eq("d_t6_valid", 32'(if_id_valid), 32'd0);
                7: expect_if_id("d_t7", 32'h3000);
                8: expect_if_id("d_t8", 32'h3004);
                default: ;
            endcase
        end

        // Wrap-around from the top of the address space; low redirect bits ignored.
        do_reset(1);
        for (int t = 0; t < 7; t++) begin
            if (t > 0) nxt();
            redirect_valid = (t == 2);
            redirect_pc    = 32'hFFFF_FFFF;
            smp();
            case (t)
                3: begin
                    check_eq("e_t3_req_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
                    check_eq("e_t3_valid",    32'(if_id_valid), 32'd0);
                end
                4: check_eq("e_t4_req_addr", imem.imem_req_addr, 32'h0);
                5: expect_if_id("e_t5", 32'hFFFF_FFFC);
                6: expect_if_id("e_t6", 32'h0);
                default: ;
            endcase
        end

        // Random request backpressure: sequential addresses, stable while held.
        do_reset(1);
        exp_addr     = 32'h100;
        exp_id       = 32'h100;
        hold_pending = 1'b0;
        held_addr    = 32'h0;
        for (int t = 0; t < 80; t++) begin
            if (t > 0) nxt();
            imem.imem_req_ready = 1'($urandom_range(0, 1));
            smp();
            if (hold_pending) begin
                check_eq("f_hold_valid", 32'(imem.imem_req_valid), 32'd1);
                check_eq("f_hold_addr",  imem.imem_req_addr, held_addr);
            end
            if (imem.imem_req_valid && imem.imem_req_ready) begin
                check_eq("f_seq_addr", imem.imem_req_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            hold_pending = imem.imem_req_valid && !imem.imem_req_ready;
            held_addr    = imem.imem_req_addr;
            if (if_id_valid) begin
                check_eq("f_id_pc",    if_id_pc,    exp_id);
                check_eq("f_id_instr", if_id_instr, instr_of(exp_id));
                exp_id = exp_id + 32'd4;
            end
        end
        check_eq("f_progress", 32'(exp_id >= 32'h140), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
